// File: rtl/bp_me_mem_cmd_serializer.sv
// Serializes a memory command (header + optional cache line) into flit-wide beats.
// Define BP_ME_SER_PARITY_EN to append an XOR parity beat to payload-carrying messages.
module bp_me_mem_cmd_serializer #(
  parameter int unsigned hdr_width_p  = 50,
  parameter int unsigned data_width_p = 512,
  parameter int unsigned flit_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [hdr_width_p-1:0]  mem_cmd_header_i,
  input  logic [data_width_p-1:0] mem_cmd_data_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [flit_width_p-1:0] data_o,
  output logic                    v_o,
  output logic                    last_o,
  input  logic                    ready_i
);

  localparam int unsigned Beats = data_width_p / flit_width_p;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'h1,
    e_mem_msg_wr    = 4'h2,
    e_mem_msg_uc_rd = 4'h3,
    e_mem_msg_uc_wr = 4'h4
  } e_mem_msg;

  localparam logic [15:0] mem_cmd_payload_mask_gp =
    (16'd1 << e_mem_msg_wr) | (16'd1 << e_mem_msg_uc_wr);

`ifdef BP_ME_SER_PARITY_EN
  localparam bit ParityEn = 1'b1;
  typedef enum logic [1:0] {StIdle, StHdr, StData, StParity} state_e;
  logic [flit_width_p-1:0] parity_q;
`else
  localparam bit ParityEn = 1'b0;
  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;
`endif

  state_e                         state_q;
  logic [CntW-1:0]                cnt_q;
  logic [Beats-1:0][flit_width_p-1:0] line_q;
  logic                           payload_q;
  logic                           ready_q;
  logic                           v_q;
  logic                           last_q;
  logic [flit_width_p-1:0]        data_q;
  logic                           has_payload;

  // Types outside the mask (including unknown encodings) are header-only.
  assign has_payload = mem_cmd_payload_mask_gp[mem_cmd_header_i[3:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      line_q    <= '0;
      payload_q <= 1'b0;
      ready_q   <= 1'b0;
      v_q       <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
`ifdef BP_ME_SER_PARITY_EN
      parity_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (mem_cmd_v_i && ready_q) begin
            line_q    <= mem_cmd_data_i;
            payload_q <= has_payload;
            data_q    <= flit_width_p'(mem_cmd_header_i);
            last_q    <= !has_payload;
            v_q       <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= StHdr;
          end
        end
        StHdr: if (ready_i) begin
          if (payload_q) begin
            state_q <= StData;
            cnt_q   <= '0;
            data_q  <= line_q[0];
            last_q  <= (LastCnt == '0) && !ParityEn;
`ifdef BP_ME_SER_PARITY_EN
            parity_q <= '0;
`endif
          end else begin
            state_q <= StIdle;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        StData: if (ready_i) begin
`ifdef BP_ME_SER_PARITY_EN
          parity_q <= parity_q ^ data_q;
`endif
          if (cnt_q == LastCnt) begin
`ifdef BP_ME_SER_PARITY_EN
            state_q <= StParity;
            data_q  <= parity_q ^ data_q;
            last_q  <= 1'b1;
`else
            state_q <= StIdle;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
`endif
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            data_q <= line_q[cnt_q + 1'b1];
            last_q <= ((cnt_q + 1'b1) == LastCnt) && !ParityEn;
          end
        end
`ifdef BP_ME_SER_PARITY_EN
        StParity: if (ready_i) begin
          state_q <= StIdle;
          cnt_q   <= '0;
          v_q     <= 1'b0;
          last_q  <= 1'b0;
          ready_q <= 1'b1;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_cmd_ready_o = ready_q;
  assign v_o             = v_q;
  assign last_o          = last_q;
  assign data_o          = data_q;

endmodule
